bootrom_arbiter: RTL

- Shares the single combinational bootrom word port between NumReq requesters, e.g. host core fetch, debug module, and chiplet-to-chiplet loader.
- Uses round-robin grant with a registered read response one cycle after grant.
- Decodes and range-checks addresses and drives the bootrom word-address pins.
- Sits between the SoC narrow-bus demux and the bootrom macro, which may be either the netlist or the simulation stand-in.

---
 rtl/bootrom_arbiter_pkg.sv | 21 ++
 rtl/bootrom_rr_arb.sv | 35 +++
 rtl/bootrom_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/bootrom_arbiter_pkg.sv
// Shared types and helpers for the bootrom arbiter: word-address width,
// registered response record and the ROM window range check.
package bootrom_arbiter_pkg;

    localparam int RomAddrBits = 11;
    localparam int RspIdxBits  = 8;

    typedef struct packed {
        logic                  valid;
        logic [RspIdxBits-1:0] idx;
        logic [31:0]           data;
        logic                  err;
    } rsp_t;

    // Offset is already relative to the ROM base (unsigned wrap applied by caller).
    function automatic logic rom_offset_in_range(input logic [63:0] off,
                                                 input logic [63:0] rom_bytes);
        return off < rom_bytes;
    endfunction

endpackage

// File: rtl/bootrom_rr_arb.sv
// Generic round-robin picker: grants the first request at or above the
// pointer, wrapping to index 0; outputs a one-hot grant and its index.
module bootrom_rr_arb #(
    parameter int NumReq = 3,
    parameter int IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0] i_req,
    input  logic [IdxW-1:0]   i_ptr,
    output logic [NumReq-1:0] o_gnt,
    output logic [IdxW-1:0]   o_idx
);

    logic [NumReq-1:0] w_hi;
    logic [NumReq-1:0] w_gnt_hi;
    logic [NumReq-1:0] w_gnt_lo;
    logic [NumReq-1:0] w_bit_sel [IdxW];

    // Requests at or above the pointer take precedence over the wrapped ones.
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_pick
        localparam logic [NumReq-1:0] LowMask = NumReq'((1 << gi) - 1);
        assign w_hi[gi]     = i_req[gi] & (IdxW'(gi) >= i_ptr);
        assign w_gnt_hi[gi] = w_hi[gi]  & ~(|(w_hi  & LowMask));
        assign w_gnt_lo[gi] = i_req[gi] & ~(|(i_req & LowMask));
    end

    assign o_gnt = (|w_hi) ? w_gnt_hi : w_gnt_lo;

    for (genvar gb = 0; gb < IdxW; gb++) begin : g_idx_bit
        for (genvar gi = 0; gi < NumReq; gi++) begin : g_idx_req
            assign w_bit_sel[gb][gi] = o_gnt[gi] & (((gi >> gb) & 1) == 1);
        end
        assign o_idx[gb] = |w_bit_sel[gb];
    end

endmodule

// File: rtl/bootrom_arbiter.sv
// Round-robin arbiter sharing one combinational bootrom word port between
// NumReq requesters. Optional counters: define BOOTROM_ARBITER_PERF_EN.
module bootrom_arbiter
    import bootrom_arbiter_pkg::*;
#(
    parameter int                   NumReq    = 3,
    parameter int                   AddrWidth = 48,
    parameter logic [AddrWidth-1:0] BaseAddr  = 48'h0000_0100_0000,
    parameter int                   RomBytes  = 1024
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumReq-1:0]                   req_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]    addr_i,
    output logic [NumReq-1:0]                   gnt_o,
    output logic [NumReq-1:0]                   rvalid_o,
    output logic [31:0]                         rdata_o,
    output logic                                err_o,
    output logic [RomAddrBits-1:0]              rom_addr_o,
`ifdef BOOTROM_ARBITER_PERF_EN
    output logic [NumReq-1:0][31:0]             perf_cnt_o,
    output logic [15:0]                         err_cnt_o,
    input  logic                                perf_clr_i,
`endif
    input  logic [31:0]                         rom_data_i
);

    localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [NumReq-1:0]      w_req;
    logic [NumReq-1:0]      w_gnt;
    logic [IdxW-1:0]        w_idx;
    logic                   w_any;
    logic [AddrWidth-1:0]   w_win_addr;
    logic [NumReq-1:0]      w_addr_t [AddrWidth];
    logic [AddrWidth-1:0]   w_off;
    logic                   w_err;
    logic [RomAddrBits-1:0] w_rom_word;

    logic [IdxW-1:0]        r_ptr;
    logic [RomAddrBits-1:0] r_rom_addr;
    rsp_t                   r_rsp;

    // Reset gates the requests so no grant is visible while rst_ni is low.
    assign w_req = req_i & {NumReq{rst_ni}};

    bootrom_rr_arb #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_rr_arb (
        .i_req  (w_req),
        .i_ptr  (r_ptr),
        .o_gnt  (w_gnt),
        .o_idx  (w_idx)
    );

    assign gnt_o = w_gnt;
    assign w_any = |w_gnt;

    // Winner address as an AND-OR mux over the one-hot grant.
    for (genvar gb = 0; gb < AddrWidth; gb++) begin : g_addr_bit
        for (genvar gi = 0; gi < NumReq; gi++) begin : g_addr_req
            assign w_addr_t[gb][gi] = addr_i[gi][gb];
        end
        assign w_win_addr[gb] = |(w_gnt & w_addr_t[gb]);
    end

    assign w_off      = w_win_addr - BaseAddr;
    assign w_rom_word = w_off[RomAddrBits+1:2];
    assign w_err      = (w_win_addr < BaseAddr)
                      | ~rom_offset_in_range(64'(w_off), 64'(RomBytes))
                      | (w_win_addr[1:0] != 2'b00);

    // Hold the last word address when idle so the ROM input stays quiet.
    assign rom_addr_o = w_any ? w_rom_word : r_rom_addr;

    if (NumReq > 1) begin : g_ptr
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_ptr <= '0;
            end else if (w_any) begin
                r_ptr <= (w_idx == IdxW'(NumReq - 1)) ? '0 : w_idx + IdxW'(1);
            end
        end
    end else begin : g_ptr_const
        assign r_ptr = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rom_addr <= '0;
            r_rsp      <= '0;
        end else if (w_any) begin
            r_rom_addr  <= w_rom_word;
            r_rsp.valid <= 1'b1;
            r_rsp.idx   <= RspIdxBits'(w_idx);
            r_rsp.data  <= w_err ? 32'h0 : rom_data_i;
            r_rsp.err   <= w_err;
        end else begin
            r_rsp.valid <= 1'b0;
        end
    end

    for (genvar gi = 0; gi < NumReq; gi++) begin : g_rvalid
        assign rvalid_o[gi] = r_rsp.valid & (r_rsp.idx == RspIdxBits'(gi));
    end

    assign rdata_o = r_rsp.data;
    assign err_o   = r_rsp.err;

`ifdef BOOTROM_ARBITER_PERF_EN
    logic [NumReq-1:0][31:0] r_perf_cnt;
    logic [15:0]             r_err_cnt;

    // Clear wins over increment; counters stick at all-ones.
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_perf
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_perf_cnt[gi] <= '0;
            end else if (perf_clr_i) begin
                r_perf_cnt[gi] <= '0;
            end else if (w_gnt[gi] && (r_perf_cnt[gi] != '1)) begin
                r_perf_cnt[gi] <= r_perf_cnt[gi] + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err_cnt <= '0;
        end else if (perf_clr_i) begin
            r_err_cnt <= '0;
        end else if (w_any && w_err && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign perf_cnt_o = r_perf_cnt;
    assign err_cnt_o  = r_err_cnt;
`endif

endmodule
